// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    // Access width encodings as driven by width_src_m.
    localparam logic [2:0] WIDTH_32  = 3'b000;
    localparam logic [2:0] WIDTH_16S = 3'b010;
    localparam logic [2:0] WIDTH_16U = 3'b110;
    localparam logic [2:0] WIDTH_8S  = 3'b001;
    localparam logic [2:0] WIDTH_8U  = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t;

    typedef enum logic [1:0] {SIZE_WORD, SIZE_HALF, SIZE_BYTE} dmem_size_t;

    // Unknown width codes fall back to a full word access.
    function automatic dmem_size_t decode_size(input logic [2:0] width);
        case (width)
            WIDTH_8S, WIDTH_8U:   return SIZE_BYTE;
            WIDTH_16S, WIDTH_16U: return SIZE_HALF;
            WIDTH_32:             return SIZE_WORD;
            default:              return SIZE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] width, input logic [1:0] addr_lo);
        case (decode_size(width))
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: byte enables and replicated store data for writes,
// right-justified word for loads, plus the misalignment flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] ram_word,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    // Decode width and lane offset into write lanes and shifted read data.
    always_comb begin
        byte_en    = 4'b1111;
        lane_wdata = store_data;
        misaligned = is_misaligned(width, addr_lo);
        case (decode_size(width))
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                lane_wdata = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                byte_en    = 4'b0011 << addr_lo;
                lane_wdata = {2{store_data[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                lane_wdata = store_data;
            end
        endcase
        // A misaligned access must never touch memory and returns zero.
        if (misaligned) begin
            byte_en = 4'b0000;
        end
        load_data = misaligned ? 32'h0 : (ram_word >> {addr_lo, 3'b000});
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte enables and an optional
// wait-state FSM that stalls the memory stage for WAIT_CYCLES cycles.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_width_i,
    output logic [31:0] rdata_o,
    output logic        rsp_valid_o,
    output logic        stall_o,
    output logic        misalign_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    if (WAIT_CYCLES > 7) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..7");
    end

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [3:0]       byte_en;
    logic [31:0]      lane_wdata;
    logic [31:0]      load_data;
    logic             misaligned;
    logic             commit;
    logic             unused_addr;

    // Upper address bits are ignored so the RAM wraps.
    assign idx         = req_addr_i[IDX_W+1:2];
    assign unused_addr = ^req_addr_i[31:IDX_W+2];

    dmem_lane_align u_lane_align (
        .width      (req_width_i),
        .addr_lo    (req_addr_i[1:0]),
        .store_data (req_wdata_i),
        .ram_word   (mem[idx]),
        .byte_en    (byte_en),
        .lane_wdata (lane_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // Byte-enabled RAM write; contents are not affected by reset.
    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
        end
    end

    if (WAIT_CYCLES == 0) begin : g_single_cycle
        assign commit      = req_valid_i & req_we_i & ~reset_i;
        assign rdata_o     = load_data;
        assign stall_o     = 1'b0;
        assign rsp_valid_o = req_valid_i & ~reset_i;
        assign misalign_o  = req_valid_i & misaligned & ~reset_i;
    end else begin : g_wait_fsm
        localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES - 1);

        dmem_state_t state;
        logic [2:0]  cnt;
        logic [31:0] rdata_q;

        // Wait-state sequencing; load data is captured on entry to DONE.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                state   <= IDLE;
                cnt     <= 3'd0;
                rdata_q <= 32'h0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid_i) begin
                            cnt <= CNT_INIT;
                            if (WAIT_CYCLES == 1) begin
                                state   <= DONE;
                                rdata_q <= load_data;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1) begin
                            state   <= DONE;
                            rdata_q <= load_data;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end

        // Inputs are held by the stalled pipeline, so DONE re-samples them
        // for the write; a flush during WAIT does not cancel the store.
        assign commit      = (state == DONE) & req_we_i & ~reset_i;
        assign rdata_o     = rdata_q;
        assign stall_o     = ~reset_i & (((state == IDLE) & req_valid_i) | (state == WAIT));
        assign rsp_valid_o = (state == DONE);
        assign misalign_o  = (state == DONE) & misaligned;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one single-cycle instance and one
// instance with three wait states.
module tb_data_mem_responder;
    import dmem_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        chk;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Single-cycle instance signals
    logic        v0, we0;
    logic [31:0] a0, wd0, rd0;
    logic [2:0]  w0;
    logic        rv0, st0, mi0;

    // Three-wait-state instance signals
    logic        v3, we3;
    logic [31:0] a3, wd3, rd3;
    logic [2:0]  w3;
    logic        rv3, st3, mi3;

    exp_t q0[$];
    exp_t q3[$];
    int   checks = 0;
    int   errors = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .INIT_FILE("")) u_n0 (
        .clk_i(clk), .reset_i(rst), .req_valid_i(v0), .req_we_i(we0), .req_addr_i(a0),
        .req_wdata_i(wd0), .req_width_i(w0), .rdata_o(rd0), .rsp_valid_o(rv0),
        .stall_o(st0), .misalign_o(mi0)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3), .INIT_FILE("")) u_n3 (
        .clk_i(clk), .reset_i(rst), .req_valid_i(v3), .req_we_i(we3), .req_addr_i(a3),
        .req_wdata_i(wd3), .req_width_i(w3), .rdata_o(rd3), .rsp_valid_o(rv3),
        .stall_o(st3), .misalign_o(mi3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever an instance signals a response.
    always @(negedge clk) begin
        if (rv0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL n0_unexpected_rsp: got a response, expected none");
            end else begin
                exp_t e;
                e = q0.pop_front();
                if (e.chk) check("n0_rdata", rd0, e.rdata);
                check("n0_misalign", {31'b0, mi0}, {31'b0, e.mis});
                check("n0_stall", {31'b0, st0}, 32'h0);
            end
        end
        if (rv3) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL n3_unexpected_rsp: got a response, expected none");
            end else begin
                exp_t e;
                e = q3.pop_front();
                if (e.chk) check("n3_rdata", rd3, e.rdata);
                check("n3_misalign", {31'b0, mi3}, {31'b0, e.mis});
                check("n3_stall_at_rsp", {31'b0, st3}, 32'h0);
            end
        end
    end

    task automatic acc0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] w, input logic [31:0] exp, input logic chk,
                        input logic mis);
        exp_t e;
        e.rdata = exp; e.chk = chk; e.mis = mis;
        q0.push_back(e);
        we0 = we; a0 = addr; wd0 = wdata; w0 = w; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
    endtask

    task automatic acc3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] w, input logic [31:0] exp, input logic chk,
                        input logic mis);
        exp_t e;
        int   stalls;
        bit   done;
        e.rdata = exp; e.chk = chk; e.mis = mis;
        q3.push_back(e);
        we3 = we; a3 = addr; wd3 = wdata; w3 = w; v3 = 1'b1;
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (rv3) done = 1'b1;
            else if (st3) stalls++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL n3_timeout: got no response within 12 cycles, expected one");
        end
        check("n3_stall_cycles", stalls, 32'd3);
        @(posedge clk); #1;
        v3 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        v0 = 0; we0 = 0; a0 = 0; wd0 = 0; w0 = WIDTH_32;
        v3 = 0; we3 = 0; a3 = 0; wd3 = 0; w3 = WIDTH_32;
        repeat (2) @(posedge clk);
        #1;
        check("rst_n0_stall", {31'b0, st0}, 32'h0);
        check("rst_n0_rsp", {31'b0, rv0}, 32'h0);
        check("rst_n0_mis", {31'b0, mi0}, 32'h0);
        check("rst_n3_stall", {31'b0, st3}, 32'h0);
        check("rst_n3_rsp", {31'b0, rv3}, 32'h0);
        check("rst_n3_rdata", rd3, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-cycle instance
        acc0(1, 32'h10, 32'hDEADBEEF, WIDTH_32, 32'h0, 0, 0);
        acc0(0, 32'h10, 32'h0, WIDTH_32, 32'hDEADBEEF, 1, 0);
        acc0(1, 32'h20, 32'h0, WIDTH_32, 32'h0, 0, 0);
        acc0(1, 32'h21, 32'h000000AA, WIDTH_8U, 32'h0, 0, 0);
        acc0(1, 32'h22, 32'h00001234, WIDTH_16U, 32'h0, 0, 0);
        acc0(0, 32'h20, 32'h0, WIDTH_32, 32'h1234AA00, 1, 0);
        acc0(0, 32'h21, 32'h0, WIDTH_8U, 32'h001234AA, 1, 0);
        acc0(0, 32'h22, 32'h0, WIDTH_16S, 32'h00001234, 1, 0);
        acc0(0, 32'h13, 32'h0, WIDTH_8S, 32'h000000DE, 1, 0);
        acc0(0, 32'h11, 32'h0, WIDTH_32, 32'h0, 1, 1);
        acc0(1, 32'h12, 32'hFFFFFFFF, WIDTH_32, 32'h0, 1, 1);
        acc0(1, 32'h13, 32'h0000FFFF, WIDTH_16U, 32'h0, 1, 1);
        acc0(0, 32'h10, 32'h0, WIDTH_32, 32'hDEADBEEF, 1, 0);
        acc0(1, 32'h1008, 32'hCAFEF00D, WIDTH_32, 32'h0, 0, 0);
        acc0(0, 32'h8, 32'h0, WIDTH_32, 32'hCAFEF00D, 1, 0);
        acc0(0, 32'h3, 32'h0, 3'b011, 32'h0, 1, 1);

        // Three-wait-state instance
        acc3(1, 32'h0, 32'h11223344, WIDTH_32, 32'h0, 0, 0);
        acc3(0, 32'h0, 32'h0, WIDTH_32, 32'h11223344, 1, 0);
        @(negedge clk);
        check("n3_idle_stall", {31'b0, st3}, 32'h0);
        check("n3_idle_rsp", {31'b0, rv3}, 32'h0);
        @(posedge clk); #1;
        acc3(1, 32'h3, 32'h0000BEEF, WIDTH_16S, 32'h0, 1, 1);
        acc3(0, 32'h0, 32'h0, WIDTH_32, 32'h11223344, 1, 0);
        acc3(0, 32'h2, 32'h0, WIDTH_8U, 32'h00001122, 1, 0);
        acc3(0, 32'h2, 32'h0, WIDTH_16U, 32'h00001122, 1, 0);

        // Flush during WAIT: the store still completes and commits.
        begin
            exp_t e;
            bit   done;
            e.rdata = 32'h0; e.chk = 1'b0; e.mis = 1'b0;
            q3.push_back(e);
            we3 = 1; a3 = 32'h4; wd3 = 32'h55667788; w3 = WIDTH_32; v3 = 1'b1;
            @(posedge clk); #1;
            v3 = 1'b0;
            done = 1'b0;
            for (int i = 0; i < 10 && !done; i++) begin
                @(negedge clk);
                if (rv3) done = 1'b1;
            end
            check("n3_flush_completes", {31'b0, done}, 32'h1);
            @(posedge clk); #1;
        end
        acc3(0, 32'h4, 32'h0, WIDTH_32, 32'h55667788, 1, 0);

        // Reset in the second WAIT cycle drops the pending store.
        we3 = 1; a3 = 32'h0; wd3 = 32'hFFFFFFFF; w3 = WIDTH_32; v3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("n3_rst_stall", {31'b0, st3}, 32'h0);
        check("n3_rst_rsp", {31'b0, rv3}, 32'h0);
        check("n3_rst_rdata", rd3, 32'h0);
        v3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        acc3(0, 32'h0, 32'h0, WIDTH_32, 32'h11223344, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("n0_pending", q0.size(), 32'h0);
        check("n3_pending", q3.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
